run_alarm_fsm: RTL and testbench

//  Downstream consumer of the 3-bit run detector's per-cycle flag Y (high when
//  the last three S samples are equal). Measures how long Y stays high and

---
 rtl/run_alarm_fsm.sv | 117 +++++++++++
 tb/tb_run_alarm_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/run_alarm_fsm.sv
// Run-length alarm: watches the run detector's Y flag, latches an alarm once a
// run reaches THRESH enabled cycles, holds it until ack, and counts alarm events.
module run_alarm_fsm #(
    parameter int THRESH = 4,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          y_in,
    input  logic          en,
    input  logic          ack,
    output logic          alarm,
    output logic [CW-1:0] run_len,
    output logic [CW-1:0] event_cnt,
    output logic          cnt_sat
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] ALARM = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [CW-1:0] MAXV = '1;
    localparam logic [CW-1:0] THR  = CW'(THRESH);

    logic [1:0]    r_state;
    logic [CW-1:0] r_run_len;
    logic [CW-1:0] r_event_cnt;
    logic          r_alarm;
    logic          r_cnt_sat;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_run_nxt;
    logic [CW-1:0] w_evt_nxt;
    logic [CW-1:0] w_run_inc;
    logic [CW-1:0] w_run_track;

    // Saturating increment and the ALARM/HOLD run tracking rule
    assign w_run_inc   = (r_run_len == MAXV) ? MAXV : r_run_len + CW'(1);
    assign w_run_track = en ? (y_in ? w_run_inc : '0) : r_run_len;

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_len;
        w_evt_nxt   = r_event_cnt;
        case (r_state)
            IDLE: begin
                if (en && y_in) begin
                    w_state_nxt = COUNT;
                    w_run_nxt   = CW'(1);
                end else begin
                    w_run_nxt   = '0;
                end
            end
            COUNT: begin
                if (en) begin
                    if (!y_in) begin
                        w_state_nxt = IDLE;
                        w_run_nxt   = '0;
                    end else if (w_run_inc == THR) begin
                        w_state_nxt = ALARM;
                        w_run_nxt   = THR;
                        if (r_event_cnt != MAXV)
                            w_evt_nxt = r_event_cnt + CW'(1);
                    end else begin
                        w_run_nxt   = w_run_inc;
                    end
                end
            end
            ALARM: begin
                w_run_nxt = w_run_track;
                if (ack) begin
                    if (y_in) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_run_nxt   = '0;
                    end
                end
            end
            HOLD: begin
                if (en && !y_in) begin
                    w_state_nxt = IDLE;
                    w_run_nxt   = '0;
                end else begin
                    w_run_nxt   = w_run_track;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_run_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_run_len   <= '0;
            r_event_cnt <= '0;
            r_alarm     <= 1'b0;
            r_cnt_sat   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_len   <= w_run_nxt;
            r_event_cnt <= w_evt_nxt;
            r_alarm     <= (w_state_nxt == ALARM);
            r_cnt_sat   <= (w_evt_nxt == MAXV);
        end
    end

    assign alarm     = r_alarm;
    assign run_len   = r_run_len;
    assign event_cnt = r_event_cnt;
    assign cnt_sat   = r_cnt_sat;

endmodule

// File: tb/tb_run_alarm_fsm.sv
// Bench for run_alarm_fsm: directed scenarios plus random traffic, checked
// against a flag-based behavioural model of the alarm rules.
module tb_run_alarm_fsm;

    localparam int THRESH = 4;
    localparam int CW     = 8;
    localparam int MAXV   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          y_in = 1'b0;
    logic          en = 1'b0;
    logic          ack = 1'b0;
    logic          alarm;
    logic [CW-1:0] run_len;
    logic [CW-1:0] event_cnt;
    logic          cnt_sat;

    int passed = 0;
    int total  = 0;

    // Reference model: alarm latched, same-run hold flag, run length, events
    bit m_alarm = 1'b0;
    bit m_hold  = 1'b0;
    int m_run   = 0;
    int m_evt   = 0;

    run_alarm_fsm #(.THRESH(THRESH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .y_in      (y_in),
        .en        (en),
        .ack       (ack),
        .alarm     (alarm),
        .run_len   (run_len),
        .event_cnt (event_cnt),
        .cnt_sat   (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit y, input bit e, input bit a);
        if (!r) begin
            m_alarm = 0; m_hold = 0; m_run = 0; m_evt = 0;
        end else begin
            if (e) m_run = y ? ((m_run < MAXV) ? m_run + 1 : MAXV) : 0;
            if (m_alarm) begin
                if (a) begin
                    m_alarm = 0;
                    m_hold  = y;
                    if (!y) m_run = 0;
                end
            end else if (m_hold) begin
                if (e && !y) m_hold = 0;
            end else if (e && y && m_run == THRESH) begin
                m_alarm = 1;
                if (m_evt < MAXV) m_evt = m_evt + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input bit r, input bit y, input bit e, input bit a);
        rst_n = r; y_in = y; en = e; ack = a;
        @(posedge clk);
        #1;
        model_step(r, y, e, a);
        chk("alarm", int'(alarm), int'(m_alarm));
        chk("run_len", int'(run_len), m_run);
        chk("event_cnt", int'(event_cnt), m_evt);
        chk("cnt_sat", int'(cnt_sat), (m_evt == MAXV) ? 1 : 0);
    endtask

    initial begin
        // 1: reset with y_in/en high
        step(0, 1, 1, 0);
        chk("reset_alarm", int'(alarm), 0);
        chk("reset_run", int'(run_len), 0);

        // 2: four-cycle run raises alarm, ack with y_in low returns to idle
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        chk("t2_alarm_up", int'(alarm), 1);
        chk("t2_evt", int'(event_cnt), 1);
        step(1, 1, 1, 0);
        step(1, 0, 1, 1);
        chk("t2_alarm_down", int'(alarm), 0);
        chk("t2_run_zero", int'(run_len), 0);

        // 3: run broken one cycle short of threshold
        step(0, 0, 0, 0);
        step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
        chk("t3_no_event", int'(event_cnt), 0);
        step(1, 0, 1, 0);

        // 4: long run, ack mid-run -> hold, no re-alarm; new run alarms again
        for (int i = 1; i <= 20; i++) step(1, 1, 1, (i == 6));
        chk("t4_hold_no_alarm", int'(alarm), 0);
        chk("t4_single_event", int'(event_cnt), 1);
        step(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        chk("t4_second_event", int'(event_cnt), 2);
        step(1, 0, 1, 1);

        // 5: enable low freezes run tracking; ack while idle is ignored
        step(1, 1, 1, 0); step(1, 1, 1, 1);
        step(1, 0, 0, 0); step(1, 1, 0, 1); step(1, 0, 0, 0);
        chk("t5_frozen", int'(run_len), 2);
        step(1, 1, 1, 0); step(1, 1, 1, 0);
        chk("t5_alarm", int'(alarm), 1);
        step(1, 0, 1, 1);

        // 6: saturate event counter, then reset mid-alarm
        step(0, 0, 0, 0);
        for (int c = 0; c < MAXV; c++) begin
            for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
            step(1, 0, 1, 1);
        end
        chk("t6_evt_max", int'(event_cnt), MAXV);
        chk("t6_sat", int'(cnt_sat), 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        chk("t6_evt_hold", int'(event_cnt), MAXV);
        chk("t6_alarm", int'(alarm), 1);
        step(0, 1, 1, 1);
        chk("t6_rst_alarm", int'(alarm), 0);
        chk("t6_rst_evt", int'(event_cnt), 0);
        chk("t6_rst_sat", int'(cnt_sat), 0);

        // Random traffic: y_in biased high, occasional ack, rare reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
